trap_controller: RTL and testbench

Machine-mode trap sequencer that sits beside the EX stage and is the entry/exit side of the exception-handler ROM at 0x1c090000. On ECALL or illegal instruction it captures `mepc`/`mcause`, flushes the pipeline through a ready handshake, and redirects fetch to the handler base. On MRET inside the handler it flushes again and redirects to `mepc + 4`. It also owns the small trap CSR set read and written by `csrr`/`csrw`.

---
 rtl/trap_pkg.sv | 24 ++
 rtl/trap_csr_file.sv | 76 +++++++
 rtl/trap_controller.sv | 128 ++++++++++++
 tb/tb_trap_controller.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
package trap_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned CSR_ADDR_WIDTH = 12;

  localparam logic [DATA_WIDTH-1:0] DEFAULT_HANDLER_BASE  = 32'h1c09_0000;
  localparam logic [DATA_WIDTH-1:0] DEFAULT_CAUSE_ECALL   = 32'd11;
  localparam logic [DATA_WIDTH-1:0] DEFAULT_CAUSE_ILLEGAL = 32'd2;

  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MSCRATCH = 12'h340;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MEPC     = 12'h341;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MCAUSE   = 12'h342;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTER_FLUSH,
    ST_ENTER_JMP,
    ST_HANDLER,
    ST_EXIT_FLUSH,
    ST_EXIT_JMP
  } trap_state_e;

endpackage

// File: rtl/trap_csr_file.sv
// Trap CSR storage (mepc/mcause, plus mscratch and the csrr/csrw port when
// TRAP_CSR_ACCESS_EN is defined). Trap capture always beats a software write.
module trap_csr_file
  import trap_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      capture,
  input  logic [DATA_WIDTH-1:0]     capture_pc,
  input  logic [DATA_WIDTH-1:0]     capture_cause,
  input  logic                      wr_allow,
  input  logic [CSR_ADDR_WIDTH-1:0] csr_addr,
  input  logic                      csr_we,
  input  logic [DATA_WIDTH-1:0]     csr_wdata,
  output logic [DATA_WIDTH-1:0]     mepc,
  output logic [DATA_WIDTH-1:0]     mcause,
  output logic                      mcause_clear_c,
  output logic [DATA_WIDTH-1:0]     csr_rdata
);

`ifdef TRAP_CSR_ACCESS_EN
  logic [DATA_WIDTH-1:0] mscratch;
  logic                  wr_en_c;

  assign wr_en_c        = csr_we && wr_allow;
  assign mcause_clear_c = wr_en_c && (csr_addr == CSR_MCAUSE) && (csr_wdata == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      mepc     <= '0;
      mcause   <= '0;
      mscratch <= '0;
    end else begin
      if (capture) begin
        mepc   <= capture_pc;
        mcause <= capture_cause;
      end else if (wr_en_c && (csr_addr == CSR_MEPC)) begin
        mepc <= csr_wdata;
      end else if (wr_en_c && (csr_addr == CSR_MCAUSE)) begin
        mcause <= csr_wdata;
      end
      if (wr_en_c && (csr_addr == CSR_MSCRATCH)) begin
        mscratch <= csr_wdata;
      end
    end
  end

  // Unmapped addresses read as zero.
  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSCRATCH: csr_rdata = mscratch;
      CSR_MEPC:     csr_rdata = mepc;
      CSR_MCAUSE:   csr_rdata = mcause;
      default:      csr_rdata = '0;
    endcase
  end
`else
  logic unused_csr_port;

  assign unused_csr_port = ^{wr_allow, csr_addr, csr_we, csr_wdata};
  assign mcause_clear_c  = 1'b0;
  assign csr_rdata       = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      mepc   <= '0;
      mcause <= '0;
    end else if (capture) begin
      mepc   <= capture_pc;
      mcause <= capture_cause;
    end
  end
`endif

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap entry/exit sequencer with pipeline flush handshake.
// Optional CSR access port is enabled by defining TRAP_CSR_ACCESS_EN.
module trap_controller
  import trap_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] HANDLER_BASE  = DEFAULT_HANDLER_BASE,
  parameter logic [DATA_WIDTH-1:0] CAUSE_ECALL   = DEFAULT_CAUSE_ECALL,
  parameter logic [DATA_WIDTH-1:0] CAUSE_ILLEGAL = DEFAULT_CAUSE_ILLEGAL
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ecall_req,
  input  logic                      illegal_req,
  input  logic                      mret_req,
  input  logic [DATA_WIDTH-1:0]     req_pc,
  input  logic                      pipe_ready,
  output logic                      flush,
  output logic                      redirect_valid,
  output logic [DATA_WIDTH-1:0]     redirect_pc,
  output logic                      in_handler,
  output logic                      nested_err,
  input  logic [CSR_ADDR_WIDTH-1:0] csr_addr,
  input  logic                      csr_we,
  input  logic [DATA_WIDTH-1:0]     csr_wdata,
  output logic [DATA_WIDTH-1:0]     csr_rdata
);

  trap_state_e           state, next_state;
  logic                  capture_c;
  logic [DATA_WIDTH-1:0] cause_c;
  logic                  nested_set_c;
  logic                  wr_allow_c;
  logic                  mcause_clear_c;
  logic [DATA_WIDTH-1:0] mepc;
  logic [DATA_WIDTH-1:0] mcause;
  logic                  flush_d;
  logic                  redirect_valid_d;
  logic [DATA_WIDTH-1:0] redirect_pc_d;
  logic                  in_handler_d;

  assign wr_allow_c = (state == ST_IDLE) || (state == ST_HANDLER);

  trap_csr_file u_csr (
    .clk            (clk),
    .rst            (rst),
    .capture        (capture_c),
    .capture_pc     (req_pc),
    .capture_cause  (cause_c),
    .wr_allow       (wr_allow_c),
    .csr_addr       (csr_addr),
    .csr_we         (csr_we),
    .csr_wdata      (csr_wdata),
    .mepc           (mepc),
    .mcause         (mcause),
    .mcause_clear_c (mcause_clear_c),
    .csr_rdata      (csr_rdata)
  );

  // State register; outputs are registered from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      in_handler     <= 1'b0;
      nested_err     <= 1'b0;
    end else begin
      state          <= next_state;
      flush          <= flush_d;
      redirect_valid <= redirect_valid_d;
      redirect_pc    <= redirect_pc_d;
      in_handler     <= in_handler_d;
      if (nested_set_c) begin
        nested_err <= 1'b1;
      end else if (mcause_clear_c) begin
        nested_err <= 1'b0;
      end
    end
  end

  always_comb begin
    next_state       = state;
    capture_c        = 1'b0;
    cause_c          = CAUSE_ECALL;
    nested_set_c     = 1'b0;
    flush_d          = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = '0;
    in_handler_d     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (illegal_req || ecall_req) begin
          capture_c  = 1'b1;
          cause_c    = illegal_req ? CAUSE_ILLEGAL : CAUSE_ECALL;
          next_state = ST_ENTER_FLUSH;
        end
      end
      ST_ENTER_FLUSH: if (pipe_ready) next_state = ST_ENTER_JMP;
      ST_ENTER_JMP:   next_state = ST_HANDLER;
      ST_HANDLER: begin
        nested_set_c = ecall_req || illegal_req;
        if (mret_req) next_state = ST_EXIT_FLUSH;
      end
      ST_EXIT_FLUSH:  if (pipe_ready) next_state = ST_EXIT_JMP;
      ST_EXIT_JMP:    next_state = ST_IDLE;
      default:        next_state = ST_IDLE;
    endcase

    // Output values for the state being entered.
    case (next_state)
      ST_ENTER_FLUSH, ST_EXIT_FLUSH: flush_d = 1'b1;
      ST_ENTER_JMP: begin
        redirect_valid_d = 1'b1;
        redirect_pc_d    = HANDLER_BASE;
      end
      ST_EXIT_JMP: begin
        redirect_valid_d = 1'b1;
        redirect_pc_d    = mepc + DATA_WIDTH'(4);
      end
      ST_HANDLER:   in_handler_d = 1'b1;
      default:      ;
    endcase
  end

endmodule

// File: tb/tb_trap_controller.sv
// Directed self-checking bench for trap_controller; CSR-port checks follow
// TRAP_CSR_ACCESS_EN.
module tb_trap_controller;
  import trap_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ecall_req, illegal_req, mret_req, pipe_ready;
  logic [31:0] req_pc;
  logic        flush, redirect_valid, in_handler, nested_err;
  logic [31:0] redirect_pc;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [31:0] csr_wdata, csr_rdata;

  int checks = 0;
  int errors = 0;

  trap_controller dut (
    .clk            (clk),
    .rst            (rst),
    .ecall_req      (ecall_req),
    .illegal_req    (illegal_req),
    .mret_req       (mret_req),
    .req_pc         (req_pc),
    .pipe_ready     (pipe_ready),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .in_handler     (in_handler),
    .nested_err     (nested_err),
    .csr_addr       (csr_addr),
    .csr_we         (csr_we),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic f, input logic rv,
                            input logic [31:0] pc, input logic ih);
    check({tag, ".flush"}, 32'(flush), 32'(f));
    check({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(rv));
    check({tag, ".redirect_pc"}, redirect_pc, pc);
    check({tag, ".in_handler"}, 32'(in_handler), 32'(ih));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_read(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    csr_addr = addr;
    #1;
    check(tag, csr_rdata, exp);
  endtask

  initial begin
    rst = 1'b1; ecall_req = 0; illegal_req = 0; mret_req = 0; pipe_ready = 0;
    req_pc = '0; csr_addr = '0; csr_we = 0; csr_wdata = '0;
    step(); step();
    rst = 1'b0;
    check_outs("reset", 0, 0, 32'h0, 0);
    check("reset.nested_err", 32'(nested_err), 32'h0);
    check("reset.csr_rdata", csr_rdata, 32'h0);

    // ECALL, pipeline ready immediately: one flush cycle then redirect.
    ecall_req = 1; req_pc = 32'h120; pipe_ready = 1;
    step();
    ecall_req = 0;
    check_outs("ecall.flush", 1, 0, 32'h0, 0);
    check("ecall.mepc", dut.u_csr.mepc, 32'h120);
    check("ecall.mcause", dut.u_csr.mcause, 32'd11);
    step();
    check_outs("ecall.jmp", 0, 1, 32'h1c090000, 0);
    step();
    check_outs("ecall.handler", 0, 0, 32'h0, 1);
    mret_req = 1;
    step();
    mret_req = 0;
    check_outs("ecall.exit_flush", 1, 0, 32'h0, 0);
    step();
    check_outs("ecall.exit_jmp", 0, 1, 32'h124, 0);
    step();
    check_outs("ecall.idle", 0, 0, 32'h0, 0);

    // MRET in IDLE is ignored.
    mret_req = 1;
    step();
    mret_req = 0;
    check_outs("idle_mret", 0, 0, 32'h0, 0);

    // Illegal + ECALL together, pipe_ready low for 3 cycles.
    illegal_req = 1; ecall_req = 1; req_pc = 32'h300; pipe_ready = 0;
    step();
    illegal_req = 0; ecall_req = 0;
    check_outs("illegal.flush0", 1, 0, 32'h0, 0);
    check("illegal.mcause", dut.u_csr.mcause, 32'd2);
    for (int i = 1; i < 4; i++) begin
      step();
      check_outs($sformatf("illegal.flush%0d", i), 1, 0, 32'h0, 0);
    end
    pipe_ready = 1;
    step();
    check_outs("illegal.jmp", 0, 1, 32'h1c090000, 0);
    step();
    check_outs("illegal.handler", 0, 0, 32'h0, 1);

    // Nested ECALL inside handler.
    ecall_req = 1; req_pc = 32'h999;
    step();
    ecall_req = 0;
    check("nested.flag", 32'(nested_err), 32'h1);
    check_outs("nested.state", 0, 0, 32'h0, 1);
    check("nested.mepc", dut.u_csr.mepc, 32'h300);
    check("nested.mcause", dut.u_csr.mcause, 32'd2);

`ifdef TRAP_CSR_ACCESS_EN
    csr_we = 1; csr_addr = 12'h342; csr_wdata = 32'h0;
    step();
    csr_addr = 12'h340; csr_wdata = 32'hdeadbeef;
    step();
    csr_we = 0;
    check("csr.nested_clear", 32'(nested_err), 32'h0);
    csr_read("csr.mcause_rd", 12'h342, 32'h0);
    csr_read("csr.mscratch_rd", 12'h340, 32'hdeadbeef);
    csr_read("csr.mepc_rd", 12'h341, 32'h300);
    csr_read("csr.unmapped_rd", 12'h343, 32'h0);
    // mepc write in the same cycle as MRET retargets the return.
    csr_we = 1; csr_addr = 12'h341; csr_wdata = 32'h200; mret_req = 1;
    step();
    csr_addr = 12'h340; csr_wdata = 32'h1; mret_req = 0;
    step();
    csr_we = 0;
    check_outs("csr_mret.jmp", 0, 1, 32'h204, 0);
    csr_read("csr.exit_write_ignored", 12'h340, 32'hdeadbeef);
    step();
    check_outs("csr_mret.idle", 0, 0, 32'h0, 0);
    // Capture beats a same-cycle mepc write in IDLE.
    ecall_req = 1; req_pc = 32'h40; csr_we = 1; csr_addr = 12'h341; csr_wdata = 32'h555;
    step();
    ecall_req = 0; csr_we = 0;
    csr_read("csr.capture_wins", 12'h341, 32'h40);
    step(); step();
    mret_req = 1;
    step();
    mret_req = 0;
    step();
    check_outs("capture.exit_jmp", 0, 1, 32'h44, 0);
    step();
`else
    // Without the CSR port, writes do nothing and reads are zero.
    csr_we = 1; csr_addr = 12'h342; csr_wdata = 32'h0;
    step();
    csr_we = 0;
    check("nocsr.nested_sticky", 32'(nested_err), 32'h1);
    csr_read("nocsr.rdata", 12'h341, 32'h0);
    mret_req = 1;
    step();
    mret_req = 0;
    step();
    check_outs("nocsr.exit_jmp", 0, 1, 32'h304, 0);
    step();
    check("nocsr.nested_still", 32'(nested_err), 32'h1);
`endif

    // mepc = 0xfffffffc wraps to 0 on return.
    ecall_req = 1; req_pc = 32'hfffffffc; pipe_ready = 1;
    step();
    ecall_req = 0;
    step(); step();
    check_outs("wrap.handler", 0, 0, 32'h0, 1);
    mret_req = 1;
    step();
    mret_req = 0;
    step();
    check_outs("wrap.exit_jmp", 0, 1, 32'h0, 0);
    step();
    check_outs("wrap.idle", 0, 0, 32'h0, 0);
    check("wrap.idle_state", 32'(dut.state), 32'(ST_IDLE));

    // Reset during ENTER_FLUSH aborts the sequence.
    ecall_req = 1; req_pc = 32'h500; pipe_ready = 0;
    step();
    ecall_req = 0;
    check_outs("abort.flush", 1, 0, 32'h0, 0);
    rst = 1; pipe_ready = 1;
    step();
    rst = 0;
    check_outs("abort.reset", 0, 0, 32'h0, 0);
    check("abort.nested_err", 32'(nested_err), 32'h0);
    check("abort.mepc", dut.u_csr.mepc, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_outs($sformatf("abort.quiet%0d", i), 0, 0, 32'h0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
